// File: rtl/decode_table.sv
// Shared decode definitions for the EX stage: multiply/divide operation
// encoding, R-type funct codes and the muldiv_unit state encoding.
package decode_table;

  // R-type funct field values that select the multiply/divide unit
  localparam logic [5:0] R_MULT  = 6'b011000;
  localparam logic [5:0] R_MULTU = 6'b011001;
  localparam logic [5:0] R_DIV   = 6'b011010;
  localparam logic [5:0] R_DIVU  = 6'b011011;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_t;

  // Signed variants need magnitude conversion and sign correction
  function automatic logic md_is_signed(md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate. Used as abs() on the operands and
// as the sign correction of the product, quotient and remainder.
module muldiv_signfix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] res_o
);

  // Negate when requested; -2^(W-1) maps onto itself, which reads
  // correctly as the unsigned magnitude 2^(W-1).
  always_comb begin
    res_o = val_i;
    if (neg_i) begin
      res_o = ~val_i + WIDTH'(1);
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one bit per cycle, shift-add multiply and
// restoring divide on magnitudes, sign correction on the way out.
//
// Handshake: a request is taken when start && ready && op != MD_NONE &&
// !cancel in the same cycle; operands are only sampled on that cycle. busy
// is high while iterating, done pulses for one cycle when hi/lo (and
// div_by_zero) are updated. cancel drops the request/operation and returns
// to IDLE next cycle without touching hi/lo.
module muldiv_unit
  import decode_table::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output md_state_t        state_o
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  md_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d;   // result (product/quotient) sign
  logic                 neg_rem_q, neg_rem_d;   // remainder follows dividend
  logic [WIDTH-1:0]     mcand_q, mcand_d;       // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]   acc_q, acc_d;           // product, or quotient in low half
  logic [WIDTH-1:0]     rem_q, rem_d;           // partial remainder
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 dbz_q, dbz_d;

  logic                 accept;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     abs_a, abs_b;

  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic                 div_take;
  logic [WIDTH-1:0]     div_rem_next;
  logic [WIDTH-1:0]     div_quo_next;

  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  assign ready       = (state_q == IDLE) || (state_q == DONE);
  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;
  assign state_o     = state_q;

  assign accept = start && ready && (op != MD_NONE) && !cancel;
  assign a_neg  = md_is_signed(op) && src_a[WIDTH-1];
  assign b_neg  = md_is_signed(op) && src_b[WIDTH-1];

  // Operand magnitudes on entry
  muldiv_signfix #(.WIDTH(WIDTH)) u_abs_a (.val_i(src_a), .neg_i(a_neg), .res_o(abs_a));
  muldiv_signfix #(.WIDTH(WIDTH)) u_abs_b (.val_i(src_b), .neg_i(b_neg), .res_o(abs_b));

  // One iteration of both datapaths; the FSM picks which one to keep
  always_comb begin
    mul_sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_next     = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift    = {rem_q, acc_q[WIDTH-1]};
    div_diff     = div_shift - {1'b0, mcand_q};
    div_take     = ~div_diff[WIDTH];
    div_rem_next = div_take ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_quo_next = {acc_q[WIDTH-2:0], div_take};
  end

  // Sign correction applied to the final iteration's values
  muldiv_signfix #(.WIDTH(2*WIDTH)) u_fix_prod (.val_i(mul_next), .neg_i(neg_res_q), .res_o(prod_fix));
  muldiv_signfix #(.WIDTH(WIDTH)) u_fix_quo (.val_i(div_quo_next), .neg_i(neg_res_q), .res_o(quo_fix));
  muldiv_signfix #(.WIDTH(WIDTH)) u_fix_rem (.val_i(div_rem_next), .neg_i(neg_rem_q), .res_o(rem_fix));

  // Next-state, datapath load/step and result capture
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          is_div_d  = md_is_div(op);
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          cnt_d     = '0;
          rem_d     = '0;
          if (md_is_div(op) && (src_b == '0)) begin
            // Deterministic divide-by-zero result, no iteration
            state_d = DONE;
            hi_d    = src_a;
            lo_d    = '1;
            dbz_d   = 1'b1;
          end else if (md_is_div(op)) begin
            state_d = CALC;
            mcand_d = abs_b;
            acc_d   = {{WIDTH{1'b0}}, abs_a};
          end else begin
            state_d = CALC;
            mcand_d = abs_a;
            acc_d   = {{WIDTH{1'b0}}, abs_b};
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (is_div_q) begin
          acc_d = {acc_q[2*WIDTH-1:WIDTH], div_quo_next};
          rem_d = div_rem_next;
        end else begin
          acc_d = mul_next;
        end
        if (cnt_q == LAST_ITER) begin
          state_d = DONE;
          dbz_d   = 1'b0;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush overrides everything and never publishes a result
    if (cancel) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = dbz_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      mcand_q   <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32) with a scoreboard monitor.
module tb_muldiv_unit;
  import decode_table::*;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic         clk;
  logic         rst_n;
  logic         start;
  md_op_t       op;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         cancel;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_by_zero;
  md_state_t    state_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // {div_by_zero, hi, lo} and the cycle in which done must appear
  logic [2*W:0] exp_q[$];
  int           exp_cyc_q[$];

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .cancel(cancel),
    .ready(ready), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_by_zero(div_by_zero), .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (act=running req=finished)");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done: cycle %0d hi=%h lo=%h (no result expected)", cyc, hi, lo);
      end else begin
        logic [2*W:0] e;
        int ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        if ({div_by_zero, hi, lo} !== e) begin
          errors++;
          $display("FAIL sb_result: act dbz=%b hi=%h lo=%h req dbz=%b hi=%h lo=%h",
                   div_by_zero, hi, lo, e[2*W], e[2*W-1:W], e[W-1:0]);
        end
        checks++;
        if (cyc != ec) begin
          errors++;
          $display("FAIL sb_latency: done at cycle %0d required %0d", cyc, ec);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: act=%h req=%h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive a request in the current cycle; the caller is positioned just
  // after a rising edge. Returns one cycle later with start dropped.
  task automatic issue(input md_op_t o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic push, input logic [W-1:0] e_hi, input logic [W-1:0] e_lo,
                       input logic e_dbz, input int lat);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    if (push) begin
      exp_q.push_back({e_dbz, e_hi, e_lo});
      exp_cyc_q.push_back(cyc + lat);
    end
    step(1);
    start = 1'b0;
    op    = MD_NONE;
    src_a = $urandom;
    src_b = $urandom;
  endtask

  // Full operation from IDLE, leaves the unit back in IDLE
  task automatic run_op(input string name, input md_op_t o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] e_hi,
                        input logic [W-1:0] e_lo, input logic e_dbz);
    int lat;
    lat = e_dbz ? 1 : LAT;
    check({name, "_ready_before"}, 96'(ready), 96'd1);
    issue(o, a, b, 1'b1, e_hi, e_lo, e_dbz, lat);
    step(lat + 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    op     = MD_NONE;
    src_a  = '0;
    src_b  = '0;
    cancel = 1'b0;
    step(2);
    check("rst_ready", 96'(ready), 96'd1);
    check("rst_busy", 96'(busy), 96'd0);
    check("rst_done", 96'(done), 96'd0);
    check("rst_hilo", 96'({div_by_zero, hi, lo}), 96'd0);
    check("rst_state", 96'(state_o), 96'(IDLE));
    rst_n = 1'b1;
    step(2);

    // MULTU max x max with busy window checks
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, LAT);
    check("multu_busy_first", 96'({busy, ready}), 96'b10);
    step(31);
    check("multu_busy_last", 96'({busy, ready}), 96'b10);
    step(1);
    check("multu_done_state", 96'({busy, ready, done}), 96'b011);
    step(1);
    check("multu_idle_after", 96'({done, state_o}), 96'({1'b0, IDLE}));

    // MULT -3 x 7, then back-to-back MULT 2 x 3 started in DONE
    step(1);
    issue(MD_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, LAT);
    step(LAT - 1);
    check("b2b_in_done", 96'({done, ready}), 96'b11);
    issue(MD_MULT, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6, 1'b0, LAT);
    check("b2b_busy", 96'(busy), 96'd1);
    step(LAT);

    // Divides
    run_op("divu_100_7", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_min_m1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    run_op("div_m100_7", MD_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0);
    run_op("divu_5_0", MD_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
    run_op("divu_9_3", MD_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0);

    // MD_NONE start is ignored
    start = 1'b1;
    op    = MD_NONE;
    step(1);
    start = 1'b0;
    check("none_ignored", 96'({busy, state_o}), 96'({1'b0, IDLE}));

    // Cancel at cycle 10 of a MULT: no done, hi/lo keep 0/3
    issue(MD_MULT, 32'd1234, 32'd5678, 1'b0, '0, '0, 1'b0, 0);
    step(9);
    cancel = 1'b1;
    step(1);
    cancel = 1'b0;
    check("cancel_ready", 96'({ready, busy}), 96'b10);
    check("cancel_hilo", 96'({div_by_zero, hi, lo}), 96'({1'b0, 32'd0, 32'd3}));
    step(40);
    check("cancel_no_result", 96'({state_o, hi, lo}), 96'({IDLE, 32'd0, 32'd3}));

    // Same-cycle start and cancel: dropped
    start  = 1'b1;
    op     = MD_DIVU;
    src_a  = 32'd50;
    src_b  = 32'd0;
    cancel = 1'b1;
    step(1);
    start  = 1'b0;
    op     = MD_NONE;
    cancel = 1'b0;
    check("start_cancel_dropped", 96'({busy, state_o}), 96'({1'b0, IDLE}));
    step(3);
    check("start_cancel_hilo", 96'({div_by_zero, hi, lo}), 96'({1'b0, 32'd0, 32'd3}));

    // Async reset at cycle 15 of a DIV
    run_op("divu_100_7b", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    issue(MD_DIV, 32'hFFFF_FF00, 32'd3, 1'b0, '0, '0, 1'b0, 0);
    step(14);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", 96'({ready, busy, done, div_by_zero}), 96'b1000);
    check("rst_mid_hilo", 96'({hi, lo}), 96'd0);
    step(2);
    rst_n = 1'b1;
    step(1);
    run_op("divu_8_2", MD_DIVU, 32'd8, 32'd2, 32'd0, 32'd4, 1'b0);

    step(5);
    check("sb_queue_empty", 96'(exp_q.size()), 96'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide engine for the EX stage. It executes MULT, MULTU, DIV and DIVU and returns a {hi, lo} pair for the HI/LO registers.
- It runs iteratively, one bit per cycle, and exposes a ready/start/done handshake so the pipeline controller can stall.
- It generalises the fixed 32-bit datapath to a parametrised WIDTH.
- It adds flush (cancel) support and a deterministic divide-by-zero result.

Parameters:
- WIDTH, 32, operand width; hi and lo are each WIDTH bits.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when ready=1
- op  input  md_op_t (3)  MD_NONE/MD_MULT/MD_MULTU/MD_DIV/MD_DIVU
- src_a  input  WIDTH  multiplicand / dividend
- src_b  input  WIDTH  multiplier / divisor
- cancel  input  1  pipeline flush; aborts the current operation
- ready  output  1  unit can accept start
- busy  output  1  operation in progress (stall request)
- done  output  1  one-cycle pulse; hi/lo valid
- hi  output  WIDTH  product high half / remainder
- lo  output  WIDTH  product low half / quotient
- div_by_zero  output  1  qualifies done; divisor was 0

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - ready=1, busy=0, done=0, div_by_zero=0.
  - hi=0, lo=0; internal accumulators cleared.
- States: IDLE, CALC, DONE.
  - ready=1 in IDLE and DONE.
  - busy=1 in CALC.
  - done=1 only in DONE.
- Accept condition: start && ready && op!=MD_NONE && !cancel.
  - On accept, latch op, sign flags and operand magnitudes.
  - Signed ops take two's-complement absolute values held in WIDTH-bit unsigned form (|-2^(W-1)| = 2^(W-1) fits).
  - counter=0; next state CALC.
  - start with op=MD_NONE is ignored.
- Divide by zero: if accepted op is DIV/DIVU and src_b==0:
  - Go directly to DONE; done rises the next cycle (latency 1).
  - hi=src_a (raw), lo={WIDTH{1}}, div_by_zero=1.
- CALC, multiply: radix-2 shift-add, one multiplier bit per cycle, 2*WIDTH-bit accumulator.
- CALC, divide: restoring shift-subtract, one quotient bit per cycle, WIDTH+1-bit partial remainder.
- CALC exit: after WIDTH iterations (counter==WIDTH-1 on the last), go to DONE.
- Sign correction is applied on the CALC->DONE transition and registered into hi/lo:
  - MULT: negate the 2W product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - DIV of -2^(W-1) by -1: lo=-2^(W-1) (wraps), hi=0. No trap.
- Latency: start accepted at cycle 0 gives done=1 in cycle WIDTH+1 (cycle 33 for WIDTH=32).
- DONE lasts one cycle.
  - Back-to-back: start accepted in DONE goes straight to CALC; done still pulses this cycle.
  - Otherwise DONE returns to IDLE.
- hi, lo and div_by_zero hold their values until the next DONE.
  - div_by_zero is cleared on any non-zero-divisor completion.
- Cancel:
  - cancel=1 in any state forces IDLE next cycle.
  - No done pulse; hi/lo keep their previous values.
  - cancel in DONE does not suppress the current done pulse (the result is already visible).
  - cancel and start in the same cycle: cancel wins, request dropped.
- Reset asserted mid-CALC: immediate return to the reset values; no partial result is exposed.
- Operand inputs are ignored except on the accept cycle; they may change freely during CALC.

Decomposition:
- Package decode_table gains:
  - md_op_t enum (MD_NONE=0, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU).
  - funct constants R_MULT=6'b011000, R_MULTU=6'b011001, R_DIV=6'b011010, R_DIVU=6'b011011.
- State enum md_state_t (IDLE, CALC, DONE) lives in the same package for bench visibility.
- One natural sub-module: muldiv_signfix, a combinational abs/negate helper parametrised by WIDTH. It is used both on entry and on exit. The iteration datapath stays in the top.

Test Plan (WIDTH=32):
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, start at cycle 0 -> busy cycles 1-32; done at cycle 33 with hi=0xFFFFFFFE, lo=0x00000001.
- MULT 0xFFFFFFFD (-3) × 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then back-to-back start in DONE of MULT 2×3 -> second done 33 cycles later, lo=6, hi=0.
- DIVU 100/7 -> lo=14, hi=2. DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 5/0 -> done at cycle 1, div_by_zero=1, hi=5, lo=0xFFFFFFFF; next DIVU 9/3 -> div_by_zero=0, lo=3, hi=0.
- MULT started, cancel at cycle 10 -> ready=1 at cycle 11, no done ever, hi/lo unchanged. Same-cycle start+cancel -> no operation.
- rst_n pulsed low asynchronously at cycle 15 of a DIV -> outputs immediately at reset values; no done; a fresh DIVU 8/2 then completes normally with lo=4.
